// File: rtl/lab2_display_pkg.sv
// rtl/lab2_display_pkg.sv - shared constants and types for the seven-segment display path
package lab2_display_pkg;

    localparam int NUM_DIGITS = 4;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
    localparam seg_t HEX_SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/hex_to_sevenseg.sv
// rtl/hex_to_sevenseg.sv - combinational nibble to active-low segment decoder
module hex_to_sevenseg
    import lab2_display_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/lab2_sevenseg_scan.sv
// rtl/lab2_sevenseg_scan.sv - four-digit common-anode scanner with guard, blanking and frame shadowing
module lab2_sevenseg_scan
    import lab2_display_pkg::*;
#(
    parameter int DIGIT_PERIOD = 100000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic [3:0]  dp_en,
    input  logic        blank_lz,
    output seg_t        seg,
    output logic        dp,
    output logic [3:0]  an
);

    localparam int CW = $clog2(DIGIT_PERIOD);

    logic [CW-1:0]          cnt;
    logic [1:0]             idx;
    logic [15:0]            shadow_val;
    logic [NUM_DIGITS-1:0]  shadow_dp;

    logic        slot_wrap;
    logic        frame_start;
    logic        in_guard;
    logic        lz_blank;
    logic [3:0]  cur_nibble;
    seg_t        dec_seg;
    logic [3:0]  an_next;
    seg_t        seg_next;
    logic        dp_next;

    assign slot_wrap   = (cnt == CW'(DIGIT_PERIOD - 1));
    // True right after reset and whenever the index has just wrapped 3 -> 0
    assign frame_start = (cnt == '0) && (idx == 2'd0);
    assign in_guard    = (cnt < CW'(GUARD_CYCLES));
    assign cur_nibble  = shadow_val[{idx, 2'b00} +: 4];

    // Digit k is a leading zero when nibbles k..3 are all zero; digit 0 always shows
    assign lz_blank = blank_lz && (idx != 2'd0) && ((shadow_val >> {idx, 2'b00}) == 16'h0000);

    hex_to_sevenseg u_dec (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

    always_comb begin
        an_next  = 4'b1111;
        seg_next = SEG_BLANK;
        dp_next  = 1'b1;
        if (!in_guard && !lz_blank) begin
            an_next  = ~(4'b0001 << idx);
            seg_next = dec_seg;
            dp_next  = ~shadow_dp[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= 2'd0;
            shadow_val <= 16'h0000;
            shadow_dp  <= '0;
            an         <= 4'b1111;
            seg        <= SEG_BLANK;
            dp         <= 1'b1;
        end else begin
            if (slot_wrap) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end
            if (frame_start) begin
                shadow_val <= value;
                shadow_dp  <= dp_en;
            end
            an  <= an_next;
            seg <= seg_next;
            dp  <= dp_next;
        end
    end

endmodule

// File: tb/tb_lab2_sevenseg_scan.sv
// tb/tb_lab2_sevenseg_scan.sv - scoreboard bench for the seven-segment scanner
module tb_lab2_sevenseg_scan;

    localparam int DP = 8;
    localparam int GC = 2;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] SA = 7'b0001000;
    localparam logic [6:0] SB = 7'b0000011;
    localparam logic [6:0] SC = 7'b1000110;
    localparam logic [6:0] SD = 7'b0100001;
    localparam logic [6:0] SX = 7'b1111111;

    logic        clk;
    logic        reset;
    logic [15:0] value;
    logic [3:0]  dp_en;
    logic        blank_lz;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;

    logic [11:0] exp_q[$];
    int n_pass;
    int n_total;

    lab2_sevenseg_scan #(
        .DIGIT_PERIOD (DP),
        .GUARD_CYCLES (GC)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .value    (value),
        .dp_en    (dp_en),
        .blank_lz (blank_lz),
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one expected {an,seg,dp} per cycle while the scoreboard holds entries
    always @(negedge clk) begin
        logic [11:0] e;
        if (!$isunknown(an)) begin
            n_total++;
            if ($countones(~an) <= 1) n_pass++;
            else $display("FAIL onehot_an: an=%b has more than one low anode", an);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_total++;
            if ({an, seg, dp} === e) n_pass++;
            else $display("FAIL scan_out @%0t: got an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b",
                          $time, an, seg, dp, e[11:8], e[7:1], e[0]);
        end
    end

    task automatic push_blank();
        exp_q.push_back({4'b1111, SX, 1'b1});
    endtask

    task automatic push_slot(input logic [3:0] a, input logic [6:0] s, input logic d, input int n_active);
        for (int i = 0; i < GC; i++) push_blank();
        for (int i = 0; i < n_active; i++) exp_q.push_back({a, s, d});
    endtask

    task automatic push_full(input logic [3:0] a, input logic [6:0] s, input logic d);
        push_slot(a, s, d, DP - GC);
    endtask

    task automatic push_dark();
        for (int i = 0; i < DP; i++) push_blank();
    endtask

    // Asserts reset between edges; the intervals following each reset edge must be blank
    task automatic do_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            push_blank();
        end
        reset = 1'b0;
    endtask

    task automatic wait_empty();
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 500) begin
            @(negedge clk);
            #1;
            i++;
        end
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain_timeout: %0d entries left, want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        reset    = 1'b1;
        value    = 16'h1234;
        dp_en    = 4'b0000;
        blank_lz = 1'b0;

        do_reset(3);
        push_full(4'b1110, S4, 1'b1);
        push_full(4'b1101, S3, 1'b1);
        push_full(4'b1011, S2, 1'b1);
        push_full(4'b0111, S1, 1'b1);
        wait_empty();

        value = 16'hABCD;
        dp_en = 4'b0100;
        do_reset(1);
        for (int f = 0; f < 2; f++) begin
            push_full(4'b1110, SD, 1'b1);
            push_full(4'b1101, SC, 1'b1);
            push_full(4'b1011, SB, 1'b0);
            push_full(4'b0111, SA, 1'b1);
        end
        wait_empty();

        value = 16'h1111;
        dp_en = 4'b0000;
        do_reset(1);
        push_full(4'b1110, S1, 1'b1);
        push_full(4'b1101, S1, 1'b1);
        push_full(4'b1011, S1, 1'b1);
        push_full(4'b0111, S1, 1'b1);
        push_full(4'b1110, S2, 1'b1);
        push_full(4'b1101, S2, 1'b1);
        push_full(4'b1011, S2, 1'b1);
        push_full(4'b0111, S2, 1'b1);
        repeat (12) @(posedge clk);
        #1 value = 16'h2222;
        wait_empty();

        blank_lz = 1'b1;
        value    = 16'h0050;
        do_reset(1);
        push_full(4'b1110, S0, 1'b1);
        push_full(4'b1101, S5, 1'b1);
        push_dark();
        push_dark();
        push_full(4'b1110, S0, 1'b1);
        push_dark();
        push_dark();
        push_dark();
        repeat (4) @(posedge clk);
        #1 value = 16'h0000;
        wait_empty();

        value = 16'h0102;
        do_reset(1);
        push_full(4'b1110, S2, 1'b1);
        push_full(4'b1101, S0, 1'b1);
        push_full(4'b1011, S1, 1'b1);
        push_dark();
        wait_empty();

        blank_lz = 1'b0;
        value    = 16'h1234;
        do_reset(1);
        push_full(4'b1110, S4, 1'b1);
        push_full(4'b1101, S3, 1'b1);
        push_slot(4'b1011, S2, 1'b1, 4);
        wait_empty();
        value = 16'h5678;
        do_reset(1);
        push_full(4'b1110, S8, 1'b1);
        push_full(4'b1101, S7, 1'b1);
        push_full(4'b1011, S6, 1'b1);
        push_full(4'b0111, S5, 1'b1);
        wait_empty();

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_total);
        $fatal(1);
    end

endmodule
